// File: rtl/instruction_cache_pkg.sv
// Shared widths, state encoding and address-split helpers for the instruction cache.
package instruction_cache_pkg;

    localparam int OFFSET_W = 2;
    localparam int LINE_W   = 128;
    localparam int LADDR_W  = 28;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_ALLOCATE = 1'b1
    } state_t;

    function automatic int index_w(input int blocks);
        return $clog2(blocks);
    endfunction

    function automatic int tag_w(input int blocks);
        return LADDR_W - $clog2(blocks);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: combinational read by index, single write port.
module icache_line_array
    import instruction_cache_pkg::*;
#(
    parameter int  BLOCKS  = 8,
    localparam int INDEX_W = index_w(BLOCKS),
    localparam int TAG_W   = tag_w(BLOCKS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line
);

    logic [BLOCKS-1:0] valid;
    logic [TAG_W-1:0]  tags  [BLOCKS];
    logic [LINE_W-1:0] lines [BLOCKS];

    // Only valid bits need reset; tag/data are never read through an invalid line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_line  = lines[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only I-cache: same-cycle hits, stall while a whole line refills.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int BLOCKS = 8,
    parameter int WORDS  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               proc_read,
    input  logic [29:0]        proc_addr,
    output logic [31:0]        proc_rdata,
    output logic               proc_stall,
    output logic               mem_read,
    output logic [LADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]  mem_rdata,
    input  logic               mem_ready
);

    localparam int INDEX_W = index_w(BLOCKS);
    localparam int TAG_W   = tag_w(BLOCKS);
    localparam int WORD_W  = LINE_W / WORDS;

    state_t state, state_next;

    logic [OFFSET_W-1:0] offset;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_line;
    logic                hit;
    logic                miss;
    logic                we;

    assign offset = proc_addr[OFFSET_W-1:0];
    assign index  = proc_addr[OFFSET_W +: INDEX_W];
    assign tag    = proc_addr[29 -: TAG_W];

    icache_line_array #(.BLOCKS(BLOCKS)) u_lines (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (we),
        .wr_index (mem_addr[INDEX_W-1:0]),
        .wr_tag   (mem_addr[LADDR_W-1 -: TAG_W]),
        .wr_line  (mem_rdata)
    );

    assign hit        = proc_read & rd_valid & (rd_tag == tag);
    assign proc_rdata = hit ? rd_line[WORD_W*offset +: WORD_W] : 32'h0;

    always_comb begin
        state_next = state;
        proc_stall = 1'b0;
        miss       = 1'b0;
        we         = 1'b0;
        case (state)
            S_IDLE: begin
                miss       = proc_read & ~hit;
                proc_stall = miss;
                if (miss) state_next = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    we         = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The refill target is latched at miss time so address changes during ALLOCATE are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mem_read <= 1'b0;
            mem_addr <= '0;
        end else begin
            state <= state_next;
            if (miss) begin
                mem_read <= 1'b1;
                mem_addr <= proc_addr[29:OFFSET_W];
            end else if (we) begin
                mem_read <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: expected fetch words queued on request, checked on service.
module tb_instruction_cache;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    instruction_cache #(.BLOCKS(8), .WORDS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_addr  (proc_addr),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word at word-address a holds 0xA + a, so line 0 is {D,C,B,A}.
    function automatic logic [31:0] word_of(input logic [29:0] a);
        return {2'b00, a} + 32'hA;
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = word_of({la, w[1:0]});
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [29:0] a);
        proc_read = 1'b1;
        proc_addr = a;
        #1;
    endtask

    task automatic issue(input logic [29:0] a);
        drive(a);
        exp_q.push_back(word_of(a));
    endtask

    task automatic serve(input string name);
        logic [31:0] e;
        chk({name, "_stall"}, proc_stall, 0);
        total++;
        assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL %s_queue observed=empty expected=entry", name);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({name, "_rdata"}, proc_rdata, e);
        end
    endtask

    // Called in the first ALLOCATE cycle; holds mem_ready off for extra cycles, then pulses it.
    task automatic refill(input string name, input logic [27:0] la, input int extra);
        chk({name, "_mem_read"}, mem_read, 1);
        chk({name, "_mem_addr"}, mem_addr, la);
        chk({name, "_alloc_stall"}, proc_stall, 1);
        for (int i = 0; i < extra; i++) begin
            step();
            chk({name, "_mem_read_hold"}, mem_read, 1);
            chk({name, "_mem_addr_hold"}, mem_addr, la);
        end
        mem_ready = 1'b1;
        mem_rdata = line_of(la);
        step();
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
        chk({name, "_mem_read_clr"}, mem_read, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        proc_read = 1'b0;
        proc_addr = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        step();
        step();
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_stall_idle", proc_stall, 0);
        chk("rst_rdata", proc_rdata, 0);
        drive(30'h1);
        chk("rst_stall_eq_read", proc_stall, 1);
        proc_read = 1'b0;
        rst_n     = 1'b1;

        // Cold miss, mem_ready three cycles after the miss
        step();
        issue(30'h1);
        chk("cold_stall", proc_stall, 1);
        chk("cold_mem_read0", mem_read, 0);
        step();
        refill("cold", 28'h0, 2);
        serve("cold");

        // Hit sweep across line 0
        for (int a = 0; a < 4; a++) begin
            step();
            issue(30'(a));
            serve("sweep");
            chk("sweep_mem_read", mem_read, 0);
        end

        // Conflict eviction on index 0
        step();
        issue(30'h20);
        chk("evict_stall", proc_stall, 1);
        step();
        refill("evict", 28'h8, 0);
        serve("evict");
        step();
        issue(30'h0);
        chk("evict_remiss", proc_stall, 1);
        step();
        refill("evict_back", 28'h0, 1);
        serve("evict_back");

        // Address changes while ALLOCATE is pending
        step();
        drive(30'h4);
        chk("chg_stall", proc_stall, 1);
        step();
        drive(30'h8);
        refill("chg", 28'h1, 1);
        chk("chg_new_miss", proc_stall, 1);
        step();
        refill("chg_second", 28'h2, 0);
        exp_q.push_back(word_of(30'h8));
        serve("chg_second");
        step();
        issue(30'h5);
        serve("chg_line1");

        // proc_read dropped during ALLOCATE still installs the line
        step();
        drive(30'hC);
        step();
        proc_read = 1'b0;
        refill("drop", 28'h3, 1);
        step();
        issue(30'hD);
        serve("drop");

        // Reset mid-refill
        step();
        drive(30'h10);
        chk("rstmid_stall", proc_stall, 1);
        step();
        chk("rstmid_mem_read1", mem_read, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_mem_read0", mem_read, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        proc_read = 1'b0;
        step();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = line_of(28'h4);
        step();
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
        chk("rstmid_idle_mem_read", mem_read, 0);
        drive(30'h10);
        chk("rstmid_late_ignored", proc_stall, 1);
        drive(30'h1);
        chk("rstmid_prior_invalid", proc_stall, 1);
        proc_read = 1'b0;

        // Spurious mem_ready in IDLE
        step();
        mem_ready = 1'b1;
        mem_rdata = line_of(28'h0);
        step();
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
        chk("spur_stall", proc_stall, 0);
        chk("spur_mem_read", mem_read, 0);
        drive(30'h0);
        chk("spur_no_install", proc_stall, 1);
        proc_read = 1'b0;
        step();

        chk("queue_drained", 128'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
